uart_tx_arbiter: RTL and testbench

Shares the board's single UART transmitter between several byte-stream requesters, such as the RX echo path and the KEYS1/KEYS2 message generator, on the Tang Nano 9K design. It arbitrates round-robin, moves one byte at a time into the transmitter over a start/busy handshake, and can lock the grant for a whole packet. It sits between the requester logic and the `uart` transmitter and owns the transmitter's `tx_start`/`tx_data` inputs.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit arbiter: FSM state encoding,
// UART byte width and the supported requester count.
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int UART_MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr,
// searching in ascending index order and wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ (2..8) byte streams, one byte per grant.
// Define UART_TX_ARB_PKT_LOCK_EN to hold the grant until the byte marked req_last.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = UART_BYTE_W,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      active
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;
    logic               accept;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_data;

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic               last_q;
`else
    logic               unused_last;
    assign unused_last = ^req_last;
`endif

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .found     (rr_found)
    );

    // Lane mux for the byte being accepted (rr winner in IDLE, locked lane in HOLD).
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        accept    = 1'b0;
        sel_idx   = rr_idx;
        case (state_q)
            IDLE: begin
                if (rr_found && !tx_busy) begin
                    req_ready = rr_grant;
                    accept    = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    if (last_q) begin
                        ptr_d   = wrap_inc(grant_id);
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
`else
                    ptr_d   = wrap_inc(grant_id);
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_PKT_LOCK_EN
            HOLD: begin
                // Only the locked lane may continue its packet; no timeout.
                sel_idx = grant_id;
                if (req_valid[grant_id] && !tx_busy) begin
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_d             = LAUNCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            tx_data  <= '0;
            grant_id <= '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            last_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                tx_data  <= sel_data;
                grant_id <= sel_idx;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                last_q   <= req_last[sel_idx];
`endif
            end
        end
    end

    assign tx_start = (state_q == LAUNCH);
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (3 lanes) with a simple transmitter model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy = 1'b0;
    logic [IDX_W-1:0]          grant_id;
    logic                      active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    typedef struct packed { logic [7:0] data; logic last; } lane_byte_t;
    typedef struct packed { logic [IDX_W-1:0] lane; logic [7:0] data; } sb_t;
    typedef struct { logic [NUM_REQ-1:0] valid; logic busy; logic [NUM_REQ-1:0] exp_ready; } vec_t;

    lane_byte_t  lane_q [NUM_REQ][$];
    sb_t         sb_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  exp_order[$];
    vec_t        vecs[9];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 1;
    int frame_len = 4;
    int ack_cnt = 0;
    int busy_cnt = 0;
    logic pend_start = 1'b0;
    logic frame_active = 1'b0;
    logic [7:0] frame_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int lane, input logic [7:0] d, input logic l);
        lane_byte_t b;
        b.data = d;
        b.last = l;
        lane_q[lane].push_back(b);
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < NUM_REQ; i++) if (lane_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lane_q[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = lane_q[i][0].data;
                req_last[i]         = lane_q[i][0].last;
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: sample/check at negedge, then update lanes and transmitter after posedge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] popped;
        logic start_now;
        sb_t e;
        @(negedge clk);
        acc = req_valid & req_ready;
        check("ready_onehot", 32'($onehot0(req_ready)), 1);
        check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
        check("start_timing", 32'(tx_start), 32'(pend_start));
        start_now = tx_start;
        if (tx_start) begin
            check("active_in_frame", 32'(active), 1);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: tx_start with no accepted byte, tx_data 0x%0h", tx_data);
            end else begin
                e = sb_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("grant_id", 32'(grant_id), 32'(e.lane));
            end
            tx_log.push_back(tx_data);
            frame_active = 1'b1;
            frame_data   = tx_data;
        end else if (frame_active) begin
            check("tx_data_stable", 32'(tx_data), 32'(frame_data));
        end
        popped = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                e.lane = IDX_W'(i);
                e.data = lane_q[i][0].data;
                sb_q.push_back(e);
                popped[i] = 1'b1;
            end
        end
        pend_start = (acc != '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (popped[i]) void'(lane_q[i].pop_front());
        drive_lanes();
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                tx_busy  = 1'b1;
                busy_cnt = frame_len;
            end
        end else if (tx_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy      = 1'b0;
                frame_active = 1'b0;
            end
        end
        if (start_now) ack_cnt = ack_delay;
    endtask

    task automatic run(input string name, input int budget);
        int  cyc = 0;
        bit  done = 1'b0;
        while (!done && cyc < budget) begin
            step();
            cyc++;
            done = lanes_empty() && sb_q.size() == 0 && !tx_busy && ack_cnt == 0 && !active && !pend_start;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: not idle after %0d cycles", name, budget);
        end
        check($sformatf("%s_count", name), tx_log.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < tx_log.size(); i++)
            check($sformatf("%s_order%0d", name, i), 32'(tx_log[i]), 32'(exp_order[i]));
        tx_log.delete();
    endtask

    initial begin
        // IDLE ready vectors with pointer at 0 (lane 0 highest priority).
        vecs[0] = '{3'b000, 1'b0, 3'b000};
        vecs[1] = '{3'b001, 1'b0, 3'b001};
        vecs[2] = '{3'b010, 1'b0, 3'b010};
        vecs[3] = '{3'b100, 1'b0, 3'b100};
        vecs[4] = '{3'b110, 1'b0, 3'b010};
        vecs[5] = '{3'b101, 1'b0, 3'b001};
        vecs[6] = '{3'b111, 1'b0, 3'b001};
        vecs[7] = '{3'b111, 1'b1, 3'b000};
        vecs[8] = '{3'b100, 1'b1, 3'b000};

        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_active", 32'(active), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        #3 rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            @(posedge clk);
            #1;
            req_valid = vecs[v].valid;
            tx_busy   = vecs[v].busy;
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            req_valid = '0;
            tx_busy   = 1'b0;
        end
        check("idle_after_vectors", 32'(active), 0);

        // Single request.
        load(0, 8'h55, 1'b1);
        exp_order = '{8'h55};
        run("single", 60);

        // Fairness: pointer now 1, so lane 1 leads and lanes alternate.
        for (int k = 0; k < 3; k++) begin
            load(0, 8'h10 + 8'(k), 1'b1);
            load(1, 8'h20 + 8'(k), 1'b1);
        end
        exp_order = '{8'h20, 8'h10, 8'h21, 8'h11, 8'h22, 8'h12};
        run("fair", 200);

        // Packet on lane 1 while lane 0 keeps requesting.
        load(1, 8'h41, 1'b0);
        load(1, 8'h42, 1'b0);
        load(1, 8'h43, 1'b1);
        load(0, 8'h30, 1'b1);
        load(0, 8'h31, 1'b1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
        exp_order = '{8'h41, 8'h42, 8'h43, 8'h30, 8'h31};
`else
        exp_order = '{8'h41, 8'h30, 8'h42, 8'h31, 8'h43};
`endif
        run("packet", 200);

        // Slow acknowledge from the transmitter.
        ack_delay = 5;
        load(1, 8'h99, 1'b1);
        exp_order = '{8'h99};
        run("slow_ack", 80);
        ack_delay = 1;

        // Reset while in WAIT_DONE with an unfinished packet on lane 1 (pointer is 2).
        load(1, 8'h77, 1'b0);
        begin
            int cyc = 0;
            while (!tx_busy && cyc < 50) begin
                step();
                cyc++;
            end
        end
        check("mid_frame_busy_reached", 32'(tx_busy), 1);
        step();
        step();
        check("mid_frame_active", 32'(active), 1);
        check("mid_frame_grant", 32'(grant_id), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_start", 32'(tx_start), 0);
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_grant_id", 32'(grant_id), 0);
        check("arst_active", 32'(active), 0);
        check("arst_req_ready", 32'(req_ready), 0);
        for (int i = 0; i < NUM_REQ; i++) lane_q[i].delete();
        sb_q.delete();
        tx_log.delete();
        tx_busy      = 1'b0;
        ack_cnt      = 0;
        frame_active = 1'b0;
        pend_start   = 1'b0;
        drive_lanes();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // All lanes at once after reset: 0,1,2 then wrap.
        for (int k = 0; k < 2; k++) begin
            load(0, 8'hA0 + 8'(k), 1'b1);
            load(1, 8'hB0 + 8'(k), 1'b1);
            load(2, 8'hC0 + 8'(k), 1'b1);
        end
        exp_order = '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1};
        run("all_lanes", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
